// File: rtl/alu_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM state encodings and operand-signedness decode helpers.
package alu_muldiv_iter_pkg;

    typedef enum logic [2:0] {
        MDOP_MUL    = 3'd0,
        MDOP_MULH   = 3'd1,
        MDOP_MULHSU = 3'd2,
        MDOP_MULHU  = 3'd3,
        MDOP_DIV    = 3'd4,
        MDOP_DIVU   = 3'd5,
        MDOP_REM    = 3'd6,
        MDOP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    // REM/REMU share op[1] inside the divide group
    function automatic logic op_is_rem(input md_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic rs1_signed(input md_op_e op);
        return (op == MDOP_MULH) || (op == MDOP_MULHSU) || (op == MDOP_DIV) || (op == MDOP_REM);
    endfunction

    function automatic logic rs2_signed(input md_op_e op);
        return (op == MDOP_MULH) || (op == MDOP_DIV) || (op == MDOP_REM);
    endfunction

endpackage

// File: rtl/alu_cond_neg.sv
// Conditional two's-complement negator, used for operand magnitudes and
// final sign correction of the muldiv result.
module alu_cond_neg #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per
// cycle on a shared 2*XLEN shift register, with sign fix-up in a final cycle.
module alu_muldiv_iter
    import alu_muldiv_iter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TAG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [XLEN-1:0]     in_rs1,
    input  logic [XLEN-1:0]     in_rs2,
    input  logic [TAG_BITS-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic [TAG_BITS-1:0] out_tag,
    output logic                busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    md_state_e             state_q, state_d;
    md_op_e                op_q, op_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]       opb_q, opb_d;
    logic                  neg_q, neg_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;

    md_op_e                in_op_e;
    logic                  sa, sb;
    logic [XLEN-1:0]       mag_a, mag_b;
    logic                  div_zero, div_ovf, special;
    logic [XLEN-1:0]       special_res;
    logic [XLEN:0]         mul_sum, div_prem, div_diff;
    logic [2*XLEN-1:0]     fix_in, fix_out;
    logic [XLEN-1:0]       fix_res;

    assign in_op_e = md_op_e'(in_op);
    assign sa      = rs1_signed(in_op_e) & in_rs1[XLEN-1];
    assign sb      = rs2_signed(in_op_e) & in_rs2[XLEN-1];

    alu_cond_neg #(.W(XLEN)) u_neg_a (.neg(sa), .in(in_rs1), .out(mag_a));
    alu_cond_neg #(.W(XLEN)) u_neg_b (.neg(sb), .in(in_rs2), .out(mag_b));

    // Divide corner cases resolve at accept time and bypass the iteration
    assign div_zero = (in_rs2 == '0);
    assign div_ovf  = ((in_op_e == MDOP_DIV) || (in_op_e == MDOP_REM))
                    && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
    assign special  = op_is_div(in_op_e) && (div_zero || div_ovf);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op_is_rem(in_op_e) ? in_rs1 : '1;
        else
            special_res = op_is_rem(in_op_e) ? '0 : in_rs1;
    end

    // Multiply: low half holds the multiplier, shifted out LSB-first.
    // Divide: low half holds the dividend, shifted MSB-first into the remainder.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_prem = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_prem - {1'b0, opb_q};

    assign fix_in = !op_is_div(op_q) ? acc_q
                  : {{XLEN{1'b0}}, op_is_rem(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0]};

    alu_cond_neg #(.W(2*XLEN)) u_neg_r (.neg(neg_q), .in(fix_in), .out(fix_out));

    assign fix_res = ((op_q == MDOP_MUL) || op_is_div(op_q)) ? fix_out[XLEN-1:0]
                                                             : fix_out[2*XLEN-1:XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        result_d = result_q;
        tag_d    = tag_q;
        if (flush) begin
            state_d = MD_IDLE;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (in_valid) begin
                        op_d  = in_op_e;
                        tag_d = in_tag;
                        cnt_d = '0;
                        if (special) begin
                            result_d = special_res;
                            state_d  = MD_DONE;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, op_is_div(in_op_e) ? mag_a : mag_b};
                            opb_d   = op_is_div(in_op_e) ? mag_b : mag_a;
                            // remainder follows the dividend; everything else the sign xor
                            neg_d   = op_is_rem(in_op_e) ? sa : (sa ^ sb);
                            state_d = MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    if (op_is_div(op_q)) begin
                        if (div_diff[XLEN])
                            acc_d = {div_prem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                        else
                            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT)
                        state_d = MD_FIX;
                end
                MD_FIX: begin
                    result_d = fix_res;
                    state_d  = MD_DONE;
                end
                MD_DONE: begin
                    if (out_ready)
                        state_d = MD_IDLE;
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            op_q     <= MDOP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end

    assign in_ready   = (state_q == MD_IDLE);
    assign out_valid  = (state_q == MD_DONE);
    assign busy       = (state_q != MD_IDLE);
    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule
